// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: 8b/10b receive word-alignment and sync-state controller.
// Ports:
//   clk, reset (async, active high), en (sync clear to LOS)
//   sym_valid/rx_raw: raw symbol in; dec_valid/dec_err/disp_err: decoder status
//   enable_reverse: bit order to decoder; bit_slip: 1-cycle slip request
//   sync_ok, state, err_cnt, slip_cnt (saturating), lock_lost (1-cycle)
module rx_sync_ctrl #(
   parameter logic [9:0] COMMA_NEG    = 10'b0011111010,
   parameter logic [9:0] COMMA_POS    = 10'b1100000101,
   parameter int         ACQ_COMMAS   = 3,
   parameter int         SLIP_TIMEOUT = 20,
   parameter int         ERR_LIMIT    = 4,
   parameter int         GOOD_RECOVER = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       sym_valid,
   input  logic [9:0] rx_raw,
   input  logic       dec_valid,
   input  logic       dec_err,
   input  logic       disp_err,
   output logic       enable_reverse,
   output logic       bit_slip,
   output logic       sync_ok,
   output logic [1:0] state,
   output logic [2:0] err_cnt,
   output logic [7:0] slip_cnt,
   output logic       lock_lost
);

   localparam logic [1:0] ST_LOS   = 2'b00;
   localparam logic [1:0] ST_CHECK = 2'b01;
   localparam logic [1:0] ST_SYNC  = 2'b10;

   localparam logic [3:0] ACQ_N   = 4'(ACQ_COMMAS);
   localparam logic [7:0] TO_LAST = 8'(SLIP_TIMEOUT - 1);
   localparam logic [2:0] ERR_N   = 3'(ERR_LIMIT);
   localparam logic [3:0] GOOD_N  = 4'(GOOD_RECOVER);

   logic [1:0] state_q, state_d;
   logic       rev_q, rev_d;
   logic       slip_q, slip_d;
   logic       lock_q, lock_d;
   logic       sync_q;
   logic [2:0] err_q, err_d;
   logic [7:0] slip_cnt_q, slip_cnt_d;
   logic [3:0] comma_q, comma_d;
   logic [7:0] to_q, to_d;
   logic [3:0] good_q, good_d;

   logic [9:0] raw_rev;
   logic       hit_n;
   logic       hit_r;
   logic       hit_cur;
   logic       bad;
   logic       clean;

   always_comb begin
      raw_rev = '0;
      for (int i = 0; i < 10; i++) begin
         raw_rev[i] = rx_raw[9-i];
      end
   end

   assign hit_n   = sym_valid &&
                    ((rx_raw == COMMA_NEG) || (rx_raw == COMMA_POS));
   assign hit_r   = sym_valid &&
                    ((raw_rev == COMMA_NEG) || (raw_rev == COMMA_POS));
   // In CHECK only commas seen in the locked-in orientation count.
   assign hit_cur = rev_q ? hit_r : hit_n;
   assign bad     = dec_valid && (dec_err || disp_err);
   assign clean   = dec_valid && !(dec_err || disp_err);

   always_comb begin
      state_d    = state_q;
      rev_d      = rev_q;
      slip_d     = 1'b0;
      lock_d     = 1'b0;
      err_d      = err_q;
      slip_cnt_d = slip_cnt_q;
      comma_d    = comma_q;
      to_d       = to_q;
      good_d     = good_q;

      if (!en) begin
         state_d = ST_LOS;
         comma_d = '0;
         to_d    = '0;
         err_d   = '0;
         good_d  = '0;
         lock_d  = (state_q == ST_SYNC);
      end else begin
         unique case (state_q)
            ST_LOS: begin
               if (hit_n) begin
                  state_d = ST_CHECK;
                  comma_d = 4'd1;
                  rev_d   = 1'b0;
                  to_d    = '0;
               end else if (hit_r) begin
                  state_d = ST_CHECK;
                  comma_d = 4'd1;
                  rev_d   = 1'b1;
                  to_d    = '0;
               end else if (sym_valid) begin
                  if (to_q == TO_LAST) begin
                     to_d   = '0;
                     slip_d = 1'b1;
                     if (slip_cnt_q != 8'hFF) begin
                        slip_cnt_d = slip_cnt_q + 8'd1;
                     end
                  end else begin
                     to_d = to_q + 8'd1;
                  end
               end
            end
            ST_CHECK: begin
               // A decode error outranks a simultaneous comma.
               if (bad) begin
                  state_d = ST_LOS;
                  comma_d = '0;
                  to_d    = '0;
                  err_d   = '0;
                  good_d  = '0;
               end else if (hit_cur) begin
                  if ((comma_q + 4'd1) >= ACQ_N) begin
                     state_d = ST_SYNC;
                     comma_d = '0;
                     err_d   = '0;
                     good_d  = '0;
                  end else begin
                     comma_d = comma_q + 4'd1;
                  end
               end
            end
            ST_SYNC: begin
               if (bad) begin
                  if ((err_q + 3'd1) == ERR_N) begin
                     state_d = ST_LOS;
                     lock_d  = 1'b1;
                     err_d   = '0;
                     good_d  = '0;
                     comma_d = '0;
                     to_d    = '0;
                  end else begin
                     err_d  = err_q + 3'd1;
                     good_d = '0;
                  end
               end else if (clean) begin
                  // A run of clean decodes retires one error.
                  if ((good_q + 4'd1) == GOOD_N) begin
                     good_d = '0;
                     if (err_q != 3'd0) begin
                        err_d = err_q - 3'd1;
                     end
                  end else begin
                     good_d = good_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = ST_LOS;
               comma_d = '0;
               to_d    = '0;
               err_d   = '0;
               good_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_LOS;
         rev_q      <= 1'b0;
         slip_q     <= 1'b0;
         lock_q     <= 1'b0;
         sync_q     <= 1'b0;
         err_q      <= '0;
         slip_cnt_q <= '0;
         comma_q    <= '0;
         to_q       <= '0;
         good_q     <= '0;
      end else begin
         state_q    <= state_d;
         rev_q      <= rev_d;
         slip_q     <= slip_d;
         lock_q     <= lock_d;
         sync_q     <= (state_d == ST_SYNC);
         err_q      <= err_d;
         slip_cnt_q <= slip_cnt_d;
         comma_q    <= comma_d;
         to_q       <= to_d;
         good_q     <= good_d;
      end
   end

   assign enable_reverse = rev_q;
   assign bit_slip       = slip_q;
   assign sync_ok        = sync_q;
   assign state          = state_q;
   assign err_cnt        = err_q;
   assign slip_cnt       = slip_cnt_q;
   assign lock_lost      = lock_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb_rx_sync_ctrl: directed, table-driven bench for rx_sync_ctrl.
// Default parameters; vectors plus hand sequences for slip, reset corners.
module tb_rx_sync_ctrl;

   localparam logic [9:0] NEG  = 10'b0011111010;
   localparam logic [9:0] REVP = 10'b1010000011;
   localparam logic [9:0] DAT  = 10'b1001110100;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       sym_valid;
   logic [9:0] rx_raw;
   logic       dec_valid;
   logic       dec_err;
   logic       disp_err;
   logic       enable_reverse;
   logic       bit_slip;
   logic       sync_ok;
   logic [1:0] state;
   logic [2:0] err_cnt;
   logic [7:0] slip_cnt;
   logic       lock_lost;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic       en;
      logic       sv;
      logic [9:0] raw;
      logic       dv;
      logic       de;
      logic       pe;
      logic [1:0] st;
      logic       sok;
      logic       rev;
      logic [2:0] err;
      logic       slip;
      logic       lock;
   } vec_t;

   vec_t tv[$];

   rx_sync_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .sym_valid      (sym_valid),
      .rx_raw         (rx_raw),
      .dec_valid      (dec_valid),
      .dec_err        (dec_err),
      .disp_err       (disp_err),
      .enable_reverse (enable_reverse),
      .bit_slip       (bit_slip),
      .sync_ok        (sync_ok),
      .state          (state),
      .err_cnt        (err_cnt),
      .slip_cnt       (slip_cnt),
      .lock_lost      (lock_lost)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic e, input logic s, input logic [9:0] r,
      input logic dv, input logic de, input logic pe,
      input logic [1:0] st, input logic sok, input logic rv,
      input logic [2:0] er, input logic sl, input logic lk);
      vec_t v;
      v.en = e; v.sv = s; v.raw = r;
      v.dv = dv; v.de = de; v.pe = pe;
      v.st = st; v.sok = sok; v.rev = rv;
      v.err = er; v.slip = sl; v.lock = lk;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d",
                  nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic s,
                        input logic [9:0] r, input logic dv,
                        input logic de, input logic pe);
      en        = e;
      sym_valid = s;
      rx_raw    = r;
      dec_valid = dv;
      dec_err   = de;
      disp_err  = pe;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input int idx);
      chk("rst_state", idx, int'(state), 0);
      chk("rst_sync", idx, int'(sync_ok), 0);
      chk("rst_rev", idx, int'(enable_reverse), 0);
      chk("rst_err", idx, int'(err_cnt), 0);
      chk("rst_slipcnt", idx, int'(slip_cnt), 0);
      chk("rst_slip", idx, int'(bit_slip), 0);
      chk("rst_lock", idx, int'(lock_lost), 0);
   endtask

   initial begin
      int np;
      int p0;
      int p1;

      // en sv raw dv de pe | st sok rev err slip lock
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b10,1,0,0,0,0));
      tv.push_back(mk(1,1,DAT ,1,1,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,0,0,0));
      tv.push_back(mk(1,1,DAT ,1,1,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,0, 2'b10,1,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,0,0,0, 2'b10,1,0,0,0,0));
      tv.push_back(mk(1,0,DAT ,0,0,0, 2'b10,1,0,0,0,0));
      tv.push_back(mk(1,1,DAT ,1,1,0, 2'b10,1,0,1,0,0));
      tv.push_back(mk(1,1,DAT ,1,0,1, 2'b10,1,0,2,0,0));
      tv.push_back(mk(1,1,DAT ,1,1,0, 2'b10,1,0,3,0,0));
      tv.push_back(mk(1,1,DAT ,1,1,0, 2'b00,0,0,0,0,1));
      tv.push_back(mk(1,0,DAT ,0,0,0, 2'b00,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,1,0, 2'b00,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,0,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b10,1,0,0,0,0));
      tv.push_back(mk(0,0,DAT ,0,0,0, 2'b00,0,0,0,0,1));
      tv.push_back(mk(0,0,DAT ,0,0,0, 2'b00,0,0,0,0,0));
      tv.push_back(mk(1,1,REVP,1,0,0, 2'b01,0,1,0,0,0));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,1,0,0,0));
      tv.push_back(mk(1,1,REVP,1,0,0, 2'b01,0,1,0,0,0));
      tv.push_back(mk(1,1,REVP,1,0,0, 2'b10,1,1,0,0,0));
      tv.push_back(mk(0,0,DAT ,0,0,0, 2'b00,0,1,0,0,1));
      tv.push_back(mk(1,1,NEG ,1,0,0, 2'b01,0,0,0,0,0));

      reset     = 1'b1;
      en        = 1'b0;
      sym_valid = 1'b0;
      rx_raw    = '0;
      dec_valid = 1'b0;
      dec_err   = 1'b0;
      disp_err  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals(0);
      reset = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i].en, tv[i].sv, tv[i].raw,
               tv[i].dv, tv[i].de, tv[i].pe);
         chk("state", i, int'(state), int'(tv[i].st));
         chk("sync_ok", i, int'(sync_ok), int'(tv[i].sok));
         chk("rev", i, int'(enable_reverse), int'(tv[i].rev));
         chk("err_cnt", i, int'(err_cnt), int'(tv[i].err));
         chk("bit_slip", i, int'(bit_slip), int'(tv[i].slip));
         chk("lock_lost", i, int'(lock_lost), int'(tv[i].lock));
      end
      chk("slip_cnt_tbl", 0, int'(slip_cnt), 0);

      // 40 non-comma symbols in LOS: slips after the 20th and 40th.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      np = 0;
      p0 = -1;
      p1 = -1;
      for (int i = 0; i < 40; i++) begin
         drive(1, 1, DAT, 1, 0, 0);
         if (bit_slip) begin
            if (np == 0) p0 = i;
            else if (np == 1) p1 = i;
            np++;
         end
      end
      chk("slip_pulses", 0, np, 2);
      chk("slip_first", 0, p0, 19);
      chk("slip_second", 0, p1, 39);
      chk("slip_cnt", 0, int'(slip_cnt), 2);
      chk("slip_state", 0, int'(state), 0);
      drive(1, 0, DAT, 0, 0, 0);
      chk("slip_width", 0, int'(bit_slip), 0);
      chk("slip_cnt_hold", 0, int'(slip_cnt), 2);

      // Reversed acquisition, one error, then async reset in SYNC.
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, REVP, 1, 0, 0);
      end
      chk("rev_sync_st", 0, int'(state), 2);
      chk("rev_sync_rev", 0, int'(enable_reverse), 1);
      drive(1, 1, DAT, 1, 1, 0);
      chk("pre_rst_err", 0, int'(err_cnt), 1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals(1);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 1, NEG, 1, 0, 0);
      chk("resume_state", 0, int'(state), 1);
      chk("resume_rev", 0, int'(enable_reverse), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
